lcd_reg_viewer: RTL and testbench



---
 rtl/lcd_view_pkg.sv | 45 ++++
 rtl/lcd_line_fmt.sv | 54 +++++
 rtl/lcd_reg_viewer.sv | 231 +++++++++++++++++++++++
 tb/tb_lcd_reg_viewer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_view_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_view_pkg
//  Description : Shared state encoding, HD44780 command bytes and ASCII
//                helpers for the two-line LCD register viewer.
//  Revision    : 1.0
// ============================================================================
package lcd_view_pkg;

    typedef enum logic [3:0] {
        PWRUP     = 4'd0,
        INIT      = 4'd1,
        FETCH_A   = 4'd2,
        CAPT_A    = 4'd3,
        FETCH_B   = 4'd4,
        CAPT_B    = 4'd5,
        SEND      = 4'd6,
        WAIT_DONE = 4'd7,
        GAP       = 4'd8,
        REFRESH   = 4'd9
    } state_t;

    localparam logic [7:0] LCD_FUNCSET = 8'h38;
    localparam logic [7:0] LCD_DISPON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR   = 8'h01;
    localparam logic [7:0] LCD_ENTRY   = 8'h06;
    localparam logic [7:0] LCD_LINE1   = 8'h80;
    localparam logic [7:0] LCD_LINE2   = 8'hC0;

    function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
        if (nib < 4'd10) return 8'h30 + {4'h0, nib};
        else             return 8'h37 + {4'h0, nib};
    endfunction

    // Only meaningful for 0..99; larger indices are never displayed as digits.
    function automatic logic [15:0] dec2ascii_2(input logic [6:0] idx);
        logic [6:0] tens;
        logic [6:0] units;
        tens  = idx / 7'd10;
        units = idx - tens * 7'd10;
        return {8'h30 + {1'b0, tens}, 8'h30 + {1'b0, units}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_line_fmt.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_line_fmt
//  Description : Maps (index, data, valid, column) to the ASCII character of
//                a "Rnn:0x<hex>" line, padded with spaces to 16 columns.
//  Revision    : 1.0
// ============================================================================
module lcd_line_fmt
    import lcd_view_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
)(
    input  logic [ADDR_W-1:0] i_idx,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    input  logic [3:0]        i_pos,
    output logic [7:0]        o_char
);

    localparam int C_NIBBLES = DATA_W / 4;

    logic [15:0] w_dec;
    logic [3:0]  w_digit;
    logic [3:0]  w_nib;

    assign w_dec   = dec2ascii_2(7'(i_idx));
    assign w_digit = i_pos - 4'd6;

    always_comb begin
        w_nib = 4'h0;
        for (int i = 0; i < C_NIBBLES; i++) begin
            if (w_digit == 4'(i)) w_nib = i_data[DATA_W-1-4*i -: 4];
        end
    end

    always_comb begin
        o_char = " ";
        case (i_pos)
            4'd0:    o_char = "R";
            4'd1:    o_char = i_valid ? w_dec[15:8] : "?";
            4'd2:    o_char = i_valid ? w_dec[7:0]  : "?";
            4'd3:    o_char = ":";
            4'd4:    o_char = "0";
            4'd5:    o_char = "x";
            default: begin
                if (i_pos >= 4'd6 && int'(i_pos) < 6 + C_NIBBLES)
                    o_char = i_valid ? hex2ascii(w_nib) : "-";
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lcd_reg_viewer.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_reg_viewer
//  Description : Fetches two register-file entries and streams them to an
//                HD44780 LCD controller as two "Rnn:0x<hex>" lines, forever.
//  Revision    : 1.0
// ============================================================================
module lcd_reg_viewer
    import lcd_view_pkg::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int DATA_W      = 32,
    parameter int POWERUP_CYC = 1048575,
    parameter int GAP_CYC     = 262142,
    parameter int REFRESH_CYC = 0,
    parameter int ADDR_W      = $clog2(NUM_REGS)
)(
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic [ADDR_W-1:0] iSEL_A,
    input  logic [ADDR_W-1:0] iSEL_B,
    input  logic              iHOLD,
    output logic [ADDR_W-1:0] oRF_ADDR,
    input  logic [DATA_W-1:0] iRF_DATA,
    output logic [7:0]        oLCD_DATA,
    output logic              oLCD_RS,
    output logic              oLCD_START,
    input  logic              iLCD_DONE,
    output logic              oFRAME_DONE
);

    localparam int C_MAX_PG  = (POWERUP_CYC > GAP_CYC) ? POWERUP_CYC : GAP_CYC;
    localparam int C_CNT_MAX = (C_MAX_PG > REFRESH_CYC) ? C_MAX_PG : REFRESH_CYC;
    localparam int C_CNT_W   = (C_CNT_MAX > 1) ? $clog2(C_CNT_MAX) : 1;

    localparam logic [C_CNT_W-1:0] C_PWR_LAST = C_CNT_W'((POWERUP_CYC > 0) ? POWERUP_CYC - 1 : 0);
    localparam logic [C_CNT_W-1:0] C_GAP_LAST = C_CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [C_CNT_W-1:0] C_REF_LAST = C_CNT_W'((REFRESH_CYC > 0) ? REFRESH_CYC - 1 : 0);
    localparam logic [ADDR_W:0]    C_NUM_REGS = (ADDR_W+1)'(NUM_REGS);

    // Byte pointer: 0..3 init commands, 4..37 the 34 frame bytes.
    localparam logic [5:0] C_PTR_INIT_LAST = 6'd3;
    localparam logic [5:0] C_PTR_LINE1     = 6'd4;
    localparam logic [5:0] C_PTR_LINE2     = 6'd21;
    localparam logic [5:0] C_PTR_LAST      = 6'd37;

    state_t              r_state, w_state_nxt;
    logic [C_CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [5:0]          r_ptr, w_ptr_nxt;
    logic [ADDR_W-1:0]   r_sel_a, w_sel_a_nxt, r_sel_b, w_sel_b_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [DATA_W-1:0]   r_dat_a, w_dat_a_nxt, r_dat_b, w_dat_b_nxt;
    logic [7:0]          r_data, w_data_nxt;
    logic                r_rs, w_rs_nxt;
    logic                r_start, w_start_nxt;
    logic                r_frame_done, w_frame_done_nxt;
    logic                w_go_frame;

    logic [5:0]          w_fptr;
    logic                w_line2;
    logic [3:0]          w_pos;
    logic                w_valid_a, w_valid_b;
    logic [7:0]          w_fmt_char;
    logic [7:0]          w_byte;
    logic                w_byte_rs;

    assign w_valid_a = ({1'b0, r_sel_a} < C_NUM_REGS);
    assign w_valid_b = ({1'b0, r_sel_b} < C_NUM_REGS);

    assign w_fptr  = r_ptr - C_PTR_LINE1;
    assign w_line2 = (w_fptr >= 6'd17);
    assign w_pos   = w_line2 ? 4'(w_fptr - 6'd18) : 4'(w_fptr - 6'd1);

    lcd_line_fmt #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fmt (
        .i_idx   (w_line2 ? r_sel_b   : r_sel_a),
        .i_data  (w_line2 ? r_dat_b   : r_dat_a),
        .i_valid (w_line2 ? w_valid_b : w_valid_a),
        .i_pos   (w_pos),
        .o_char  (w_fmt_char)
    );

    always_comb begin
        w_byte    = w_fmt_char;
        w_byte_rs = 1'b1;
        case (r_ptr)
            6'd0:        begin w_byte = LCD_FUNCSET; w_byte_rs = 1'b0; end
            6'd1:        begin w_byte = LCD_DISPON;  w_byte_rs = 1'b0; end
            6'd2:        begin w_byte = LCD_CLEAR;   w_byte_rs = 1'b0; end
            6'd3:        begin w_byte = LCD_ENTRY;   w_byte_rs = 1'b0; end
            C_PTR_LINE1: begin w_byte = LCD_LINE1;   w_byte_rs = 1'b0; end
            C_PTR_LINE2: begin w_byte = LCD_LINE2;   w_byte_rs = 1'b0; end
            default:     ;
        endcase
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_ptr_nxt        = r_ptr;
        w_sel_a_nxt      = r_sel_a;
        w_sel_b_nxt      = r_sel_b;
        w_addr_nxt       = r_addr;
        w_dat_a_nxt      = r_dat_a;
        w_dat_b_nxt      = r_dat_b;
        w_data_nxt       = r_data;
        w_rs_nxt         = r_rs;
        w_start_nxt      = r_start;
        w_frame_done_nxt = 1'b0;
        w_go_frame       = 1'b0;

        case (r_state)
            PWRUP: begin
                if (r_cnt >= C_PWR_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = INIT;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_W'(1);
                end
            end
            INIT: begin
                w_ptr_nxt   = 6'd0;
                w_state_nxt = SEND;
            end
            // The read address is registered on entry so the 1-cycle
            // registered RF returns data during the CAPT state.
            FETCH_A: w_state_nxt = CAPT_A;
            CAPT_A: begin
                if (w_valid_a) w_dat_a_nxt = iRF_DATA;
                w_sel_b_nxt = iSEL_B;
                w_addr_nxt  = iSEL_B;
                w_state_nxt = FETCH_B;
            end
            FETCH_B: w_state_nxt = CAPT_B;
            CAPT_B: begin
                if (w_valid_b) w_dat_b_nxt = iRF_DATA;
                w_state_nxt = SEND;
            end
            SEND: begin
                w_data_nxt  = w_byte;
                w_rs_nxt    = w_byte_rs;
                w_start_nxt = 1'b1;
                w_state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (iLCD_DONE) begin
                    w_start_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = GAP;
                end
            end
            GAP: begin
                if (r_cnt >= C_GAP_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_ptr == C_PTR_LAST) begin
                        w_frame_done_nxt = 1'b1;
                        if (REFRESH_CYC > 0) w_state_nxt = REFRESH;
                        else                 w_go_frame  = 1'b1;
                    end else if (r_ptr == C_PTR_INIT_LAST) begin
                        w_go_frame = 1'b1;
                    end else begin
                        w_ptr_nxt   = r_ptr + 6'd1;
                        w_state_nxt = SEND;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_W'(1);
                end
            end
            REFRESH: begin
                if (r_cnt >= C_REF_LAST) begin
                    w_cnt_nxt  = '0;
                    w_go_frame = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_W'(1);
                end
            end
            default: w_state_nxt = PWRUP;
        endcase

        if (w_go_frame) begin
            w_ptr_nxt = C_PTR_LINE1;
            if (iHOLD) begin
                w_state_nxt = SEND;
            end else begin
                w_sel_a_nxt = iSEL_A;
                w_addr_nxt  = iSEL_A;
                w_state_nxt = FETCH_A;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_state      <= PWRUP;
            r_cnt        <= '0;
            r_ptr        <= '0;
            r_sel_a      <= '0;
            r_sel_b      <= '0;
            r_addr       <= '0;
            r_dat_a      <= '0;
            r_dat_b      <= '0;
            r_data       <= '0;
            r_rs         <= 1'b0;
            r_start      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ptr        <= w_ptr_nxt;
            r_sel_a      <= w_sel_a_nxt;
            r_sel_b      <= w_sel_b_nxt;
            r_addr       <= w_addr_nxt;
            r_dat_a      <= w_dat_a_nxt;
            r_dat_b      <= w_dat_b_nxt;
            r_data       <= w_data_nxt;
            r_rs         <= w_rs_nxt;
            r_start      <= w_start_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign oRF_ADDR    = r_addr;
    assign oLCD_DATA   = r_data;
    assign oLCD_RS     = r_rs;
    assign oLCD_START  = r_start;
    assign oFRAME_DONE = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_lcd_reg_viewer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_reg_viewer
//  Description : Self-checking bench for lcd_reg_viewer with a 3-cycle LCD
//                controller model and a registered register-file model.
//  Revision    : 1.0
// ============================================================================
module tb_lcd_reg_viewer;

    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 6;

    logic              iCLK = 1'b0;
    logic              iRST_N = 1'b0;
    logic [ADDR_W-1:0] iSEL_A = '0;
    logic [ADDR_W-1:0] iSEL_B = '0;
    logic              iHOLD = 1'b0;
    logic [ADDR_W-1:0] oRF_ADDR;
    logic [DATA_W-1:0] iRF_DATA = '0;
    logic [7:0]        oLCD_DATA;
    logic              oLCD_RS;
    logic              oLCD_START;
    logic              iLCD_DONE;
    logic              oFRAME_DONE;

    logic [DATA_W-1:0] regs [64];
    logic              lcd_done = 1'b0;
    logic              lcd_busy = 1'b0;
    int                lcd_cnt  = 0;
    logic              spur     = 1'b0;

    int errors = 0;
    int checks = 0;
    int n_frames = 0;
    int n_addr_chg = 0;
    int n_unstable = 0;
    int addr_snap = 0;
    logic              prev_start = 1'b0;
    logic              prev_done  = 1'b0;
    logic [8:0]        prev_byte  = '0;
    logic [ADDR_W-1:0] prev_addr  = '0;
    logic [8:0]        q_obs[$];
    logic [8:0]        q_exp[$];

    lcd_reg_viewer #(
        .NUM_REGS    (NUM_REGS),
        .DATA_W      (DATA_W),
        .POWERUP_CYC (8),
        .GAP_CYC     (2),
        .REFRESH_CYC (4),
        .ADDR_W      (ADDR_W)
    ) dut (
        .iCLK        (iCLK),
        .iRST_N      (iRST_N),
        .iSEL_A      (iSEL_A),
        .iSEL_B      (iSEL_B),
        .iHOLD       (iHOLD),
        .oRF_ADDR    (oRF_ADDR),
        .iRF_DATA    (iRF_DATA),
        .oLCD_DATA   (oLCD_DATA),
        .oLCD_RS     (oLCD_RS),
        .oLCD_START  (oLCD_START),
        .iLCD_DONE   (iLCD_DONE),
        .oFRAME_DONE (oFRAME_DONE)
    );

    always #5 iCLK = ~iCLK;

    assign iLCD_DONE = lcd_done | spur;

    always @(posedge iCLK) iRF_DATA <= regs[oRF_ADDR];

    // LCD controller: done pulses 3 cycles after start is seen.
    always @(posedge iCLK) begin
        lcd_done <= 1'b0;
        if (!iRST_N) begin
            lcd_busy <= 1'b0;
            lcd_cnt  <= 0;
        end else if (lcd_busy) begin
            if (lcd_cnt == 2) begin
                lcd_done <= 1'b1;
                lcd_busy <= 1'b0;
            end else begin
                lcd_cnt <= lcd_cnt + 1;
            end
        end else if (oLCD_START && !lcd_done) begin
            lcd_busy <= 1'b1;
            lcd_cnt  <= 0;
        end
    end

    always @(negedge iCLK) begin
        if (oLCD_START && !prev_start) q_obs.push_back({oLCD_RS, oLCD_DATA});
        if (oLCD_START && prev_start && {oLCD_RS, oLCD_DATA} != prev_byte) n_unstable <= n_unstable + 1;
        if (prev_start && !oLCD_START && !prev_done && iRST_N) n_unstable <= n_unstable + 1;
        if (oFRAME_DONE) n_frames <= n_frames + 1;
        if (oRF_ADDR != prev_addr) n_addr_chg <= n_addr_chg + 1;
        prev_start <= oLCD_START;
        prev_done  <= iLCD_DONE;
        prev_byte  <= {oLCD_RS, oLCD_DATA};
        prev_addr  <= oRF_ADDR;
    end

    function automatic void push_frame(input string l1, input string l2);
        q_exp.push_back({1'b0, 8'h80});
        for (int i = 0; i < 16; i++) q_exp.push_back({1'b1, l1[i]});
        q_exp.push_back({1'b0, 8'hC0});
        for (int i = 0; i < 16; i++) q_exp.push_back({1'b1, l2[i]});
    endfunction

    function automatic void push_init();
        q_exp.push_back({1'b0, 8'h38});
        q_exp.push_back({1'b0, 8'h0C});
        q_exp.push_back({1'b0, 8'h01});
        q_exp.push_back({1'b0, 8'h06});
    endfunction

    task automatic wait_obs(input int n, output bit ok);
        int c;
        c = 0;
        while (q_obs.size() < n && c < 3000) begin
            @(negedge iCLK);
            c++;
        end
        ok = (q_obs.size() >= n);
    endtask

    task automatic test_reset();
        bit ok;
        int bad;
        int k;
        logic [8:0] e, g;
        iRST_N = 1'b0;
        repeat (3) @(negedge iCLK);
        checks++; if (oLCD_START !== 1'b0) begin errors++; $display("FAIL reset_start got=%0b want=0", oLCD_START); end
        checks++; if (oLCD_DATA !== 8'h00) begin errors++; $display("FAIL reset_data got=%02h want=00", oLCD_DATA); end
        checks++; if (oLCD_RS !== 1'b0) begin errors++; $display("FAIL reset_rs got=%0b want=0", oLCD_RS); end
        checks++; if (oRF_ADDR !== '0) begin errors++; $display("FAIL reset_addr got=%0d want=0", oRF_ADDR); end
        checks++; if (oFRAME_DONE !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%0b want=0", oFRAME_DONE); end
        q_obs.delete();
        iRST_N = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge iCLK);
            if (oLCD_START) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL powerup_idle start_cycles got=%0d want=0", bad); end
        push_init();
        wait_obs(4, ok);
        if (!ok) begin checks++; errors++; $display("FAIL init_timeout got=%0d bytes want=4", q_obs.size()); end
        k = 0;
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            g = (q_obs.size() > 0) ? q_obs.pop_front() : 9'h1FF;
            checks++;
            if (g !== e) begin errors++; $display("FAIL init[%0d] got=%03h want=%03h", k, g, e); end
            k++;
        end
    endtask

    task automatic test_frame();
        bit ok;
        int f0, k, c;
        logic [8:0] e, g;
        f0 = n_frames;
        push_frame("R05:0xDEADBEEF  ", "R31:0x00000001  ");
        wait_obs(1, ok);
        iSEL_B = 6'd40;
        wait_obs(34, ok);
        if (!ok) begin checks++; errors++; $display("FAIL frame1_timeout got=%0d bytes want=34", q_obs.size()); end
        k = 0;
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            g = (q_obs.size() > 0) ? q_obs.pop_front() : 9'h1FF;
            checks++;
            if (g !== e) begin errors++; $display("FAIL frame1[%0d] got=%03h want=%03h", k, g, e); end
            k++;
        end
        c = 0;
        while (n_frames == f0 && c < 100) begin @(negedge iCLK); c++; end
        repeat (3) @(negedge iCLK);
        checks++; if (n_frames != f0 + 1) begin errors++; $display("FAIL frame1_done pulses got=%0d want=1", n_frames - f0); end
    endtask

    task automatic test_out_of_range();
        bit ok;
        int f0, k, c;
        logic [8:0] e, g;
        f0 = n_frames;
        push_frame("R05:0xDEADBEEF  ", "R??:0x--------  ");
        wait_obs(1, ok);
        iHOLD   = 1'b1;
        iSEL_A  = 6'd3;
        regs[5] = 32'h12345678;
        addr_snap = n_addr_chg;
        wait_obs(34, ok);
        if (!ok) begin checks++; errors++; $display("FAIL oor_timeout got=%0d bytes want=34", q_obs.size()); end
        k = 0;
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            g = (q_obs.size() > 0) ? q_obs.pop_front() : 9'h1FF;
            checks++;
            if (g !== e) begin errors++; $display("FAIL oor[%0d] got=%03h want=%03h", k, g, e); end
            k++;
        end
        c = 0;
        while (n_frames == f0 && c < 100) begin @(negedge iCLK); c++; end
        repeat (3) @(negedge iCLK);
        checks++; if (n_frames != f0 + 1) begin errors++; $display("FAIL oor_done pulses got=%0d want=1", n_frames - f0); end
    endtask

    task automatic test_hold();
        bit ok;
        int f0, k, c;
        logic [8:0] e, g;
        f0 = n_frames;
        push_frame("R05:0xDEADBEEF  ", "R??:0x--------  ");
        wait_obs(1, ok);
        iHOLD  = 1'b0;
        iSEL_A = 6'd5;
        wait_obs(34, ok);
        if (!ok) begin checks++; errors++; $display("FAIL hold_timeout got=%0d bytes want=34", q_obs.size()); end
        k = 0;
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            g = (q_obs.size() > 0) ? q_obs.pop_front() : 9'h1FF;
            checks++;
            if (g !== e) begin errors++; $display("FAIL hold[%0d] got=%03h want=%03h", k, g, e); end
            k++;
        end
        checks++; if (n_addr_chg != addr_snap) begin errors++; $display("FAIL hold_addr_changes got=%0d want=0", n_addr_chg - addr_snap); end
        checks++; if (oRF_ADDR !== 6'd40) begin errors++; $display("FAIL hold_addr got=%0d want=40", oRF_ADDR); end
        c = 0;
        while (n_frames == f0 && c < 100) begin @(negedge iCLK); c++; end
        repeat (3) @(negedge iCLK);
        checks++; if (n_frames != f0 + 1) begin errors++; $display("FAIL hold_done pulses got=%0d want=1", n_frames - f0); end
    endtask

    task automatic test_spurious();
        bit ok;
        int f0, k, c;
        logic [8:0] e, g;
        f0 = n_frames;
        push_frame("R05:0x12345678  ", "R??:0x--------  ");
        for (int s = 0; s < 30; s++) begin
            c = 0;
            while (!oLCD_START && c < 200) begin @(negedge iCLK); c++; end
            while (oLCD_START && c < 400) begin @(negedge iCLK); c++; end
            spur = 1'b1;
            @(negedge iCLK);
            spur = 1'b0;
        end
        wait_obs(34, ok);
        if (!ok) begin checks++; errors++; $display("FAIL spur_timeout got=%0d bytes want=34", q_obs.size()); end
        k = 0;
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            g = (q_obs.size() > 0) ? q_obs.pop_front() : 9'h1FF;
            checks++;
            if (g !== e) begin errors++; $display("FAIL spur[%0d] got=%03h want=%03h", k, g, e); end
            k++;
        end
        c = 0;
        while (n_frames == f0 && c < 100) begin @(negedge iCLK); c++; end
        repeat (3) @(negedge iCLK);
        checks++; if (n_frames != f0 + 1) begin errors++; $display("FAIL spur_done pulses got=%0d want=1", n_frames - f0); end
        checks++; if (n_unstable != 0) begin errors++; $display("FAIL handshake_stability events got=%0d want=0", n_unstable); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int bad, k;
        logic [8:0] e, g;
        wait_obs(20, ok);
        checks++; if (!ok || oLCD_START !== 1'b1) begin errors++; $display("FAIL midreset_wait got start=%0b bytes=%0d want start=1 bytes=20", oLCD_START, q_obs.size()); end
        iRST_N = 1'b0;
        @(negedge iCLK);
        checks++; if (oLCD_START !== 1'b0) begin errors++; $display("FAIL midreset_start got=%0b want=0", oLCD_START); end
        @(negedge iCLK);
        q_obs.delete();
        iRST_N = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge iCLK);
            if (oLCD_START) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL midreset_idle start_cycles got=%0d want=0", bad); end
        push_init();
        wait_obs(4, ok);
        if (!ok) begin checks++; errors++; $display("FAIL midreset_timeout got=%0d bytes want=4", q_obs.size()); end
        k = 0;
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            g = (q_obs.size() > 0) ? q_obs.pop_front() : 9'h1FF;
            checks++;
            if (g !== e) begin errors++; $display("FAIL reinit[%0d] got=%03h want=%03h", k, g, e); end
            k++;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) regs[i] = 32'h0;
        regs[5]  = 32'hDEADBEEF;
        regs[31] = 32'h00000001;
        regs[3]  = 32'hCAFE0003;
        iSEL_A   = 6'd5;
        iSEL_B   = 6'd31;
        test_reset();
        test_frame();
        test_out_of_range();
        test_hold();
        test_spurious();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
